// File: rtl/attitude_pkg.sv
// Shared types and helpers for the attitude level tracker.
// Contents: per-axis state enum, axis index constants, and a saturating
// absolute-value-to-whole-degrees conversion.
package attitude_pkg;

    typedef enum logic [1:0] {
        LEVEL      = 2'd0,
        PEND_TILT  = 2'd1,
        TILTED     = 2'd2,
        PEND_LEVEL = 2'd3
    } axis_state_t;

    localparam int unsigned AXIS_ROLL  = 0;
    localparam int unsigned AXIS_PITCH = 1;

    // |sample| in whole degrees. The sample arrives sign-extended to 32 bits.
    // The most-negative data_width value clamps to the largest positive one.
    function automatic logic [31:0] abs_deg(input logic [31:0] sample_ext,
                                            input int unsigned data_width,
                                            input int unsigned frac_bits);
        logic [31:0] mag;
        logic [31:0] max_mag;
        max_mag = (32'd1 << (data_width - 1)) - 32'd1;
        if (sample_ext[31]) begin
            mag = (~sample_ext) + 32'd1;
        end else begin
            mag = sample_ext;
        end
        if (mag > max_mag) begin
            mag = max_mag;
        end
        return mag >> frac_bits;
    endfunction

endpackage

// File: rtl/axis_level_fsm.sv
// Per-axis level detector: magnitude, threshold compare, and a debounced
// LEVEL/TILTED state machine with a hysteresis band.
// Ports: clk, rst_n (async active-low), sample_valid, sample (signed raw),
//        level_c (level after this sample, combinational),
//        sign_c (MSB of this sample, combinational).
module axis_level_fsm
    import attitude_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned FRAC_BITS        = 4,
    parameter int unsigned LEVEL_DEG        = 10,
    parameter int unsigned HYST_DEG         = 2,
    parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic                  level_c,
    output logic                  sign_c
);

    localparam int unsigned        CNT_W    = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [CNT_W-1:0]   CNT_DONE = CNT_W'(DEBOUNCE_SAMPLES);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [31:0]        TILT_TH  = 32'(LEVEL_DEG + HYST_DEG);
    localparam logic [31:0]        LEVEL_TH = 32'(LEVEL_DEG);

    axis_state_t      state;
    axis_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      deg;
    logic             tilt_q;
    logic             lvl_q;

    // Sample qualification; band samples satisfy neither flag.
    always_comb begin
        deg    = abs_deg(32'(signed'(sample)), DATA_WIDTH, FRAC_BITS);
        tilt_q = deg > TILT_TH;
        lvl_q  = deg <= LEVEL_TH;
        cnt_inc = cnt + CNT_ONE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LEVEL;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state: a pending move completes on the DEBOUNCE_SAMPLES-th
    // qualifying sample; anything else falls back to the stable state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (sample_valid) begin
            case (state)
                LEVEL: begin
                    if (tilt_q) begin
                        if (CNT_DONE == CNT_ONE) begin
                            state_next = TILTED;
                        end else begin
                            state_next = PEND_TILT;
                            cnt_next   = CNT_ONE;
                        end
                    end
                end
                PEND_TILT: begin
                    if (!tilt_q) begin
                        state_next = LEVEL;
                        cnt_next   = '0;
                    end else if (cnt_inc == CNT_DONE) begin
                        state_next = TILTED;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                TILTED: begin
                    if (lvl_q) begin
                        if (CNT_DONE == CNT_ONE) begin
                            state_next = LEVEL;
                        end else begin
                            state_next = PEND_LEVEL;
                            cnt_next   = CNT_ONE;
                        end
                    end
                end
                PEND_LEVEL: begin
                    if (!lvl_q) begin
                        state_next = TILTED;
                        cnt_next   = '0;
                    end else if (cnt_inc == CNT_DONE) begin
                        state_next = LEVEL;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                default: begin
                    state_next = LEVEL;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs reflect the post-sample state so the qualifying sample shows
    // up in the same registered update.
    always_comb begin
        level_c = (state_next == LEVEL) || (state_next == PEND_TILT);
        sign_c  = sample[DATA_WIDTH-1];
    end

endmodule

// File: rtl/attitude_level_tracker.sv
// Debounced roll/pitch attitude tracker producing registered sign and
// level bits per axis.
// Ports: i_Clk, i_Rst_L (async active-low), i_Sample_Valid, i_Angles
//        (axis k at [k*DATA_WIDTH +: DATA_WIDTH]), o_Attitude (signs above
//        levels, axis 0 in the most significant position of each field),
//        o_Valid, o_Changed.
// Build option: ATT_SIGN_HOLD_EN forces a sign bit to 0 while its axis is level.
module attitude_level_tracker
    import attitude_pkg::*;
#(
    parameter int unsigned NUM_AXES         = 2,
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned FRAC_BITS        = 4,
    parameter int unsigned LEVEL_DEG        = 10,
    parameter int unsigned HYST_DEG         = 2,
    parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst_L,
    input  logic                           i_Sample_Valid,
    input  logic [NUM_AXES*DATA_WIDTH-1:0] i_Angles,
    output logic [2*NUM_AXES-1:0]          o_Attitude,
    output logic                           o_Valid,
    output logic                           o_Changed
);

    localparam logic [2*NUM_AXES-1:0] ATT_RESET = {{NUM_AXES{1'b0}}, {NUM_AXES{1'b1}}};

    // Parameter sanity.
    if (NUM_AXES < AXIS_ROLL + 1) begin : g_chk_axes
        $error("NUM_AXES must be at least 1");
    end
    if (DEBOUNCE_SAMPLES < 1) begin : g_chk_debounce
        $error("DEBOUNCE_SAMPLES must be at least 1");
    end
    if (DATA_WIDTH < 2 || DATA_WIDTH > 31) begin : g_chk_width
        $error("DATA_WIDTH must be in 2..31");
    end
    if ((64'(LEVEL_DEG + HYST_DEG) << FRAC_BITS) >= (64'd1 << (DATA_WIDTH - 1))) begin : g_chk_range
        $error("tilt threshold does not fit in the sample range");
    end

    logic [NUM_AXES-1:0]   level_c;
    logic [NUM_AXES-1:0]   sign_c;
    logic [2*NUM_AXES-1:0] attitude_c;

    for (genvar k = 0; k < NUM_AXES; k++) begin : g_axis
        axis_level_fsm #(
            .DATA_WIDTH       (DATA_WIDTH),
            .FRAC_BITS        (FRAC_BITS),
            .LEVEL_DEG        (LEVEL_DEG),
            .HYST_DEG         (HYST_DEG),
            .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES)
        ) u_axis (
            .clk          (i_Clk),
            .rst_n        (i_Rst_L),
            .sample_valid (i_Sample_Valid),
            .sample       (i_Angles[k*DATA_WIDTH +: DATA_WIDTH]),
            .level_c      (level_c[k]),
            .sign_c       (sign_c[k])
        );
    end

    // Pack the next attitude word; axis 0 lands in the top bit of each field.
    always_comb begin
        attitude_c = '0;
        for (int k = 0; k < NUM_AXES; k++) begin
            attitude_c[NUM_AXES-1-k] = level_c[k];
`ifdef ATT_SIGN_HOLD_EN
            attitude_c[2*NUM_AXES-1-k] = sign_c[k] & ~level_c[k];
`else
            attitude_c[2*NUM_AXES-1-k] = sign_c[k];
`endif
        end
    end

    // Output register; o_Changed compares against the last published word.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Attitude <= ATT_RESET;
            o_Valid    <= 1'b0;
            o_Changed  <= 1'b0;
        end else begin
            o_Valid <= i_Sample_Valid;
            if (i_Sample_Valid) begin
                o_Attitude <= attitude_c;
                o_Changed  <= attitude_c != o_Attitude;
            end else begin
                o_Changed <= 1'b0;
            end
        end
    end

endmodule

// File: doc/attitude_level_tracker.md
Name: attitude_level_tracker

Overview:
- Parametrised, clocked successor to the combinational roll/pitch attitude encoder.
- Takes NUM_AXES signed fixed-point angle samples per valid strobe and emits a registered attitude word of sign bits and "is-level" bits.
- Level detection uses a hysteresis band and N-sample debounce per axis, so output does not chatter near the threshold.
- Sits between the IMU sample unpacker and the LED/display attitude driver.

Parameters:
- NUM_AXES, 2, number of angle channels; axis 0 = roll, axis 1 = pitch.
- DATA_WIDTH, 16, width of each signed two's-complement sample.
- FRAC_BITS, 4, fractional bits; 1 deg = 2^FRAC_BITS LSB.
- LEVEL_DEG, 10, integer-degree bound; |deg| <= LEVEL_DEG counts as level.
- HYST_DEG, 2, extra band; a level axis goes tilted only when |deg| > LEVEL_DEG+HYST_DEG.
- DEBOUNCE_SAMPLES, 4, consecutive qualifying samples needed to change level state; must be >= 1.

Ports:
- i_Clk  input  1  system clock.
- i_Rst_L  input  1  asynchronous active-low reset.
- i_Sample_Valid  input  1  one-cycle strobe; i_Angles is valid this cycle.
- i_Angles  input  NUM_AXES*DATA_WIDTH  packed samples; axis k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_Attitude  output  2*NUM_AXES  [NUM_AXES-1+NUM_AXES : NUM_AXES] = sign per axis (1 = negative); [NUM_AXES-1:0] = level per axis. For NUM_AXES=2: [sgn roll, sgn pitch, lvl roll, lvl pitch].
- o_Valid  output  1  one-cycle pulse; o_Attitude updated.
- o_Changed  output  1  one-cycle pulse, coincident with o_Valid, when the new o_Attitude differs from the previous value.

Behaviour:
- Clock and reset: i_Clk only; reset is asynchronous and active-low on i_Rst_L. Reset wins over a simultaneous i_Sample_Valid.
- Reset values:
  - o_Attitude: all sign bits 0, all level bits 1 (level, positive).
  - o_Valid = 0, o_Changed = 0.
  - Every axis FSM in LEVEL, debounce counter = 0.
- Per-axis arithmetic on each i_Sample_Valid:
  - sign = MSB of the sample.
  - mag = |sample|; the most-negative value saturates to 2^(DATA_WIDTH-1)-1.
  - deg = mag >> FRAC_BITS (unsigned integer truncation).
  - tilt_q = deg > LEVEL_DEG+HYST_DEG.
  - lvl_q = deg <= LEVEL_DEG.
- Per-axis FSM (advances only on i_Sample_Valid; holds otherwise):
  - LEVEL: tilt_q -> PEND_TILT with cnt=1; if DEBOUNCE_SAMPLES==1, go straight to TILTED.
  - PEND_TILT: tilt_q -> cnt+1; when cnt reaches DEBOUNCE_SAMPLES -> TILTED. Any non-tilt_q sample -> LEVEL with cnt=0.
  - TILTED: lvl_q -> PEND_LEVEL with cnt=1; if DEBOUNCE_SAMPLES==1, go straight to LEVEL.
  - PEND_LEVEL: lvl_q -> cnt+1; when cnt reaches DEBOUNCE_SAMPLES -> LEVEL. Any non-lvl_q sample -> TILTED with cnt=0.
  - Samples inside the band (LEVEL_DEG < deg <= LEVEL_DEG+HYST_DEG) cancel any pending transition. Stable state is unchanged.
- Output:
  - Level bit = 1 while the FSM is in LEVEL or PEND_TILT.
  - Sign bit = sign of the latest sample.
  - Latency: o_Attitude, o_Valid and o_Changed update on the clock edge after the i_Sample_Valid cycle. The qualifying DEBOUNCE_SAMPLES-th sample is reflected in that same update.
  - Back-to-back strobes every cycle are supported (throughput 1 sample/cycle).
  - o_Changed compares against the previously registered o_Attitude.
- Counter width: $clog2(DEBOUNCE_SAMPLES+1); no wrap is possible.
- Elaboration checks: DEBOUNCE_SAMPLES >= 1; (LEVEL_DEG+HYST_DEG) << FRAC_BITS < 2^(DATA_WIDTH-1).

Optional Feature:
- Macro: ATT_SIGN_HOLD_EN.
- Defined: while an axis's level bit is 1, its sign bit is forced to 0. This suppresses sign flicker around 0 deg; the true sign appears once the axis is tilted.
- Undefined: the sign bit always follows the latest sample's MSB.

Decomposition:
- Package attitude_pkg holds:
  - the axis-state enum (LEVEL, PEND_TILT, TILTED, PEND_LEVEL);
  - axis index constants AXIS_ROLL=0 and AXIS_PITCH=1;
  - a function for saturating absolute value and degree conversion.
- Sub-module axis_level_fsm: per-axis magnitude, compare, state and counter. It is instantiated NUM_AXES times via generate.
- The top level packs the outputs and produces o_Valid and o_Changed.

Test Plan (defaults; 1 deg = 16 LSB, tilt at deg >= 13 i.e. raw >= 208, level at raw <= 175):
- Reset: hold i_Rst_L=0 mid-stream -> o_Attitude=4'b0011, o_Valid=0 immediately, without waiting for a clock edge. After release, the first sample roll=0, pitch=0 gives o_Attitude=4'b0011, o_Valid=1, o_Changed=0.
- Debounce: roll=208 on 4 consecutive strobes -> level bit stays 1 for samples 1-3 with o_Changed=0. After sample 4, o_Attitude=4'b0001 with o_Changed=1.
- Interrupted pending: roll=208, 208, 208, 176, 208 -> roll stays level (bit1=1) throughout.
- Hysteresis band: roll tilted, then 10 samples of raw 192 (deg 12) -> stays tilted. Then 4 samples of 160 -> level bit 1 after the 4th.
- Negative/saturation: pitch=0x8000 x4 -> bit2=1, bit0=0 after the 4th. Pitch=-100 (deg 6) in LEVEL -> bit2=1 without ATT_SIGN_HOLD_EN, and 0 with it.
- Throughput: strobe every cycle for 20 cycles -> o_Valid high 20 consecutive cycles, each lagging its input by exactly 1 cycle.
